// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU decode stage)
// and the sequencer state encoding.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_XOR = 4'b0011,
      OP_SUB = 4'b0100,
      OP_SLT = 4'b0101,
      OP_SLL = 4'b0110,
      OP_SRL = 4'b0111,
      OP_SRA = 4'b1000,
      OP_BEQ = 4'b1001,
      OP_BNE = 4'b1010,
      OP_BLT = 4'b1011,
      OP_BGE = 4'b1100,
      OP_JAL = 4'b1101
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath. Shift codes pass SrcA through unchanged: this is
// the zero-shift result; nonzero shifts are iterated by the sequencer.
module alu_comb
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [3:0]            op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  taken
);

   localparam logic [DATA_WIDTH-2:0] ZEROS = '0;

   logic lt_s;
   logic eq;

   assign lt_s = $signed(a) < $signed(b);
   assign eq   = (a == b);

   always_comb begin
      result = '0;
      taken  = 1'b0;
      case (op)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_ADD: result = a + b;
         OP_XOR: result = a ^ b;
         OP_SUB: result = a - b;
         OP_SLT: result = {ZEROS, lt_s};
         OP_SLL, OP_SRL, OP_SRA: result = a;
         OP_BEQ: begin
            taken  = eq;
            result = {ZEROS, eq};
         end
         OP_BNE: begin
            taken  = !eq;
            result = {ZEROS, !eq};
         end
         OP_BLT: begin
            taken  = lt_s;
            result = {ZEROS, lt_s};
         end
         OP_BGE: begin
            taken  = !lt_s;
            result = {ZEROS, !lt_s};
         end
         OP_JAL: taken = 1'b1;
         default: begin
            result = '0;
            taken  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete in one cycle, shifts iterate one
// bit per cycle. valid/ready: a transfer happens on a rising edge where both are 1.
module seq_alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Taken,
   output state_t                state
);

   localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] comb_result;
   logic                  comb_taken;
   logic [DATA_WIDTH-1:0] work;
   logic [DATA_WIDTH-1:0] shifted;
   logic [SHAMT_W-1:0]    cnt;
   logic [SHAMT_W-1:0]    shamt;
   logic [3:0]            op_q;
   logic                  start_shift;

   alu_comb #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_alu_comb (
      .op     (Operation),
      .a      (SrcA),
      .b      (SrcB),
      .result (comb_result),
      .taken  (comb_taken)
   );

   // Upper SrcB bits are deliberately ignored for the shift amount.
   assign shamt       = SrcB[SHAMT_W-1:0];
   assign start_shift = is_shift(Operation) && (shamt != '0);

   always_comb begin
      shifted = work;
      case (op_q)
         OP_SLL:  shifted = {work[DATA_WIDTH-2:0], 1'b0};
         OP_SRL:  shifted = {1'b0, work[DATA_WIDTH-1:1]};
         OP_SRA:  shifted = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
         default: shifted = work;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         work      <= '0;
         op_q      <= '0;
         ALUResult <= '0;
         Taken     <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else if (flush) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         ALUResult <= '0;
         Taken     <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  op_q     <= Operation;
                  if (start_shift) begin
                     state <= ST_SHIFT;
                     work  <= SrcA;
                     cnt   <= shamt;
                  end else begin
                     state     <= ST_DONE;
                     ALUResult <= comb_result;
                     Taken     <= comb_taken;
                     out_valid <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               work <= shifted;
               cnt  <= cnt - CNT_ONE;
               // The last shift step lands directly in the result register.
               if (cnt == CNT_ONE) begin
                  state     <= ST_DONE;
                  ALUResult <= shifted;
                  Taken     <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

   a_ready_idle: assert property (@(posedge clk) disable iff (!reset)
      in_ready == (state == ST_IDLE));

   a_valid_done: assert property (@(posedge clk) disable iff (!reset)
      out_valid == (state == ST_DONE));

   a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
      (out_valid && !out_ready && !flush) |=>
         (out_valid && $stable(ALUResult) && $stable(Taken)));

endmodule
